// File: rtl/fp_pkg.sv
// Shared types, field widths and class-bit indices for the FP alignment stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 32;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Bit positions inside the 3-bit {nan, inf, zero} class vector.
  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // OR of the bits that a right shift of m by sh discards.
  function automatic logic shifted_out_or(input logic [MANT_W-1:0] m, input logic [8:0] sh);
    logic [MANT_W-1:0] mask;
    mask = ~({MANT_W{1'b1}} << sh);
    return |(m & mask);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one single-precision operand: class flags,
// effective exponent and the {hidden, frac, 8'h00} working mantissa.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic [2:0]        cls_o,
  output logic              sign_o,
  output logic [EXP_W-1:0]  eff_exp_o,
  output logic [MANT_W-1:0] mant_o
);

  logic [EXP_W-1:0]  exp_s;
  logic [FRAC_W-1:0] frac_s;
  logic              exp_zero_s;
  logic              exp_max_s;
  logic              frac_zero_s;

  assign exp_s       = op_i[30:23];
  assign frac_s      = op_i[22:0];
  assign exp_zero_s  = (exp_s == 8'h00);
  assign exp_max_s   = (exp_s == EXP_MAX);
  assign frac_zero_s = (frac_s == 23'h000000);

  // Denormals carry a zero hidden bit and behave as exponent 1.
  always_comb begin
    cls_o           = 3'b000;
    cls_o[CLS_NAN]  = exp_max_s && !frac_zero_s;
    cls_o[CLS_INF]  = exp_max_s && frac_zero_s;
    cls_o[CLS_ZERO] = exp_zero_s && frac_zero_s;
    sign_o          = op_i[31];
    eff_exp_o       = exp_zero_s ? 8'h01 : exp_s;
    mant_o          = {!exp_zero_s, frac_s, 8'h00};
  end

endmodule

// File: rtl/fp_align_stage.sv
// Single-precision alignment stage: classify, order, align and add/subtract mantissas.
// Defining FP_ALIGN_FAST_EN replaces the serial aligner with a capture-cycle barrel shift.
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int unsigned SAT_SHIFT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      aligned_result,
  output logic             carry_out,
  output logic             aligned_sign,
  output logic [EXP_W-1:0] exponent_out,
  output logic             sticky,
  output logic [2:0]       a_class,
  output logic [2:0]       b_class,
  output logic             sign_a,
  output logic             sign_b,
  output logic [31:0]      a_out,
  output logic [31:0]      b_out
);

  localparam logic [8:0] SAT_D = 9'(SAT_SHIFT);

  logic [2:0]        cls_a_s, cls_b_s;
  logic              opsign_a_s, opsign_b_s;
  logic [EXP_W-1:0]  eexp_a_s, eexp_b_s;
  logic [MANT_W-1:0] mant_a_s, mant_b_s;

  fp_classify u_cls_a (
    .op_i      (a),
    .cls_o     (cls_a_s),
    .sign_o    (opsign_a_s),
    .eff_exp_o (eexp_a_s),
    .mant_o    (mant_a_s)
  );

  fp_classify u_cls_b (
    .op_i      (b),
    .cls_o     (cls_b_s),
    .sign_o    (opsign_b_s),
    .eff_exp_o (eexp_b_s),
    .mant_o    (mant_b_s)
  );

  // Ordering by magnitude; ties keep a as the larger operand.
  logic              a_ge_s;
  logic              special_s;
  logic              sat_s;
  logic              big_sign_s;
  logic [MANT_W-1:0] big_mant_s, small_mant_s;
  logic [EXP_W-1:0]  big_exp_s, small_exp_s;
  logic [8:0]        exp_diff_s, shift_s;

  assign a_ge_s       = (eexp_a_s > eexp_b_s) || ((eexp_a_s == eexp_b_s) && (mant_a_s >= mant_b_s));
  assign special_s    = (cls_a_s != 3'b000) || (cls_b_s != 3'b000);
  assign big_mant_s   = a_ge_s ? mant_a_s : mant_b_s;
  assign small_mant_s = a_ge_s ? mant_b_s : mant_a_s;
  assign big_exp_s    = a_ge_s ? eexp_a_s : eexp_b_s;
  assign small_exp_s  = a_ge_s ? eexp_b_s : eexp_a_s;
  assign big_sign_s   = a_ge_s ? opsign_a_s : opsign_b_s;
  assign exp_diff_s   = {1'b0, big_exp_s - small_exp_s};
  assign sat_s        = (exp_diff_s >= SAT_D);
  assign shift_s      = sat_s ? SAT_D : exp_diff_s;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       result_q, result_d;
  logic              carry_q, carry_d;
  logic              asign_q, asign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sticky_out_q, sticky_out_d;
  logic [2:0]        a_class_q, a_class_d;
  logic [2:0]        b_class_q, b_class_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [31:0]       a_out_q, a_out_d;
  logic [31:0]       b_out_q, b_out_d;
  logic [MANT_W-1:0] big_q, big_d;
  logic [MANT_W-1:0] small_q, small_d;
  logic              big_sign_q, big_sign_d;
  logic              eff_sub_q, eff_sub_d;
  logic              acc_sticky_q, acc_sticky_d;
`ifndef FP_ALIGN_FAST_EN
  logic [8:0]        cnt_q, cnt_d;
`endif

  logic [MANT_W:0]   sum_s;
  logic [MANT_W-1:0] dif_s;

  // On subtraction the sticky bit stands in for all bits lost below the LSB.
  assign sum_s = {1'b0, big_q} + {1'b0, small_q};
  assign dif_s = big_q - (small_q | {{(MANT_W-1){1'b0}}, acc_sticky_q});

  // Next-state logic for the control FSM and every datapath register.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    carry_d      = carry_q;
    asign_d      = asign_q;
    exp_d        = exp_q;
    sticky_out_d = sticky_out_q;
    a_class_d    = a_class_q;
    b_class_d    = b_class_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    big_d        = big_q;
    small_d      = small_q;
    big_sign_d   = big_sign_q;
    eff_sub_d    = eff_sub_q;
    acc_sticky_d = acc_sticky_q;
`ifndef FP_ALIGN_FAST_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_out_d    = a;
          b_out_d    = b;
          sign_a_d   = opsign_a_s;
          sign_b_d   = opsign_b_s;
          a_class_d  = cls_a_s;
          b_class_d  = cls_b_s;
          in_ready_d = 1'b0;
          if (special_s) begin
            result_d     = 32'h0000_0000;
            carry_d      = 1'b0;
            sticky_out_d = 1'b0;
            asign_d      = 1'b0;
            exp_d        = 8'h00;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
          end else begin
            big_d      = big_mant_s;
            big_sign_d = big_sign_s;
            eff_sub_d  = opsign_a_s ^ opsign_b_s;
            exp_d      = big_exp_s;
`ifdef FP_ALIGN_FAST_EN
            small_d      = sat_s ? {MANT_W{1'b0}} : (small_mant_s >> shift_s);
            acc_sticky_d = sat_s ? (|small_mant_s) : shifted_out_or(small_mant_s, shift_s);
            state_d      = ADD;
`else
            small_d      = sat_s ? {MANT_W{1'b0}} : small_mant_s;
            acc_sticky_d = sat_s ? (|small_mant_s) : 1'b0;
            cnt_d        = shift_s;
            state_d      = (shift_s == 9'd0) ? ADD : ALIGN;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
`ifdef FP_ALIGN_FAST_EN
        state_d    = IDLE;
        in_ready_d = 1'b1;
`else
        acc_sticky_d = acc_sticky_q | small_q[0];
        small_d      = small_q >> 1;
        cnt_d        = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          state_d = ADD;
        end else begin
          state_d = ALIGN;
        end
`endif
      end
      ADD: begin
        sticky_out_d = acc_sticky_q;
        if (eff_sub_q) begin
          result_d = dif_s;
          carry_d  = 1'b0;
          asign_d  = (dif_s == 32'h0000_0000) ? 1'b0 : big_sign_q;
        end else begin
          result_d = sum_s[MANT_W-1:0];
          carry_d  = sum_s[MANT_W];
          asign_d  = big_sign_q;
        end
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      result_q     <= 32'h0000_0000;
      carry_q      <= 1'b0;
      asign_q      <= 1'b0;
      exp_q        <= 8'h00;
      sticky_out_q <= 1'b0;
      a_class_q    <= 3'b000;
      b_class_q    <= 3'b000;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      a_out_q      <= 32'h0000_0000;
      b_out_q      <= 32'h0000_0000;
      big_q        <= {MANT_W{1'b0}};
      small_q      <= {MANT_W{1'b0}};
      big_sign_q   <= 1'b0;
      eff_sub_q    <= 1'b0;
      acc_sticky_q <= 1'b0;
`ifndef FP_ALIGN_FAST_EN
      cnt_q        <= 9'd0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      asign_q      <= asign_d;
      exp_q        <= exp_d;
      sticky_out_q <= sticky_out_d;
      a_class_q    <= a_class_d;
      b_class_q    <= b_class_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      big_q        <= big_d;
      small_q      <= small_d;
      big_sign_q   <= big_sign_d;
      eff_sub_q    <= eff_sub_d;
      acc_sticky_q <= acc_sticky_d;
`ifndef FP_ALIGN_FAST_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign aligned_result = result_q;
  assign carry_out      = carry_q;
  assign aligned_sign   = asign_q;
  assign exponent_out   = exp_q;
  assign sticky         = sticky_out_q;
  assign a_class        = a_class_q;
  assign b_class        = b_class_q;
  assign sign_a         = sign_a_q;
  assign sign_b         = sign_b_q;
  assign a_out          = a_out_q;
  assign b_out          = b_out_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed vector table, stall/reset sequences
// and randomized operands checked against an arithmetic reference model.
module tb_fp_align_stage;

  localparam int SAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aligned_result;
  logic        carry_out;
  logic        aligned_sign;
  logic [7:0]  exponent_out;
  logic        sticky;
  logic [2:0]  a_class;
  logic [2:0]  b_class;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_out;
  logic [31:0] b_out;

  always #5 clk = ~clk;

  fp_align_stage #(.SAT_SHIFT(SAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .aligned_result (aligned_result),
    .carry_out      (carry_out),
    .aligned_sign   (aligned_sign),
    .exponent_out   (exponent_out),
    .sticky         (sticky),
    .a_class        (a_class),
    .b_class        (b_class),
    .sign_a         (sign_a),
    .sign_b         (sign_b),
    .a_out          (a_out),
    .b_out          (b_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        carry;
    logic        sign;
    logic [7:0]  expo;
    logic        st;
    logic [2:0]  ac;
    logic [2:0]  bc;
    int          lat;   // serial-build latency; 1 marks a special operand
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] res,
                              input logic carry, input logic sign, input logic [7:0] expo,
                              input logic st, input logic [2:0] ac, input logic [2:0] bc, input int lat);
    vec_t v;
    v.a = ta; v.b = tb; v.res = res; v.carry = carry; v.sign = sign;
    v.expo = expo; v.st = st; v.ac = ac; v.bc = bc; v.lat = lat;
    return v;
  endfunction

  function automatic logic [2:0] cls3(input logic [31:0] x);
    return {x[30:23] == 8'hFF && x[22:0] != 23'd0,
            x[30:23] == 8'hFF && x[22:0] == 23'd0,
            x[30:23] == 8'h00 && x[22:0] == 23'd0};
  endfunction

  // Reference: integer mantissas, divide/remainder by 2^d for alignment and sticky.
  function automatic vec_t model(input logic [31:0] ta, input logic [31:0] tb);
    vec_t   v;
    longint ma, mb, big, sml, sh, r;
    int     ea, eb, d;
    logic   bsign, st;
    v.a = ta; v.b = tb; v.ac = cls3(ta); v.bc = cls3(tb);
    v.res = 32'd0; v.carry = 1'b0; v.sign = 1'b0; v.expo = 8'd0; v.st = 1'b0; v.lat = 1;
    if (v.ac != 3'b000 || v.bc != 3'b000) return v;
    ea = (ta[30:23] == 8'd0) ? 1 : int'(ta[30:23]);
    eb = (tb[30:23] == 8'd0) ? 1 : int'(tb[30:23]);
    ma = longint'(ta[22:0]) * 256;
    mb = longint'(tb[22:0]) * 256;
    if (ta[30:23] != 8'd0) ma = ma + (longint'(1) << 31);
    if (tb[30:23] != 8'd0) mb = mb + (longint'(1) << 31);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      big = ma; sml = mb; bsign = ta[31]; d = ea - eb;
    end else begin
      big = mb; sml = ma; bsign = tb[31]; d = eb - ea;
    end
    if (d > SAT) d = SAT;
    sh = sml / (longint'(1) << d);
    st = (sml % (longint'(1) << d)) != 0;
    if (ta[31] == tb[31]) begin
      r = big + sh;
      v.res = r[31:0]; v.carry = r[32]; v.sign = bsign;
    end else begin
      r = big - (sh | longint'(st));
      v.res = r[31:0]; v.carry = 1'b0; v.sign = (r == 0) ? 1'b0 : bsign;
    end
    v.expo = 8'((ea > eb) ? ea : eb);
    v.st = st;
    v.lat = d + 2;
    return v;
  endfunction

  function automatic int exp_lat(input int l);
`ifdef FP_ALIGN_FAST_EN
    return (l == 1) ? 1 : 2;
`else
    return l;
`endif
  endfunction

  task automatic check_hold(input vec_t v, input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(1'b0));
    chk({tag, ".result"}, 64'(aligned_result), 64'(v.res));
    chk({tag, ".carry"}, 64'(carry_out), 64'(v.carry));
    chk({tag, ".sticky"}, 64'(sticky), 64'(v.st));
    chk({tag, ".a_class"}, 64'(a_class), 64'(v.ac));
    chk({tag, ".b_class"}, 64'(b_class), 64'(v.bc));
    chk({tag, ".a_out"}, 64'(a_out), 64'(v.a));
    chk({tag, ".b_out"}, 64'(b_out), 64'(v.b));
    chk({tag, ".sign_a"}, 64'(sign_a), 64'(v.a[31]));
    chk({tag, ".sign_b"}, 64'(sign_b), 64'(v.b[31]));
    if (v.lat != 1) begin
      chk({tag, ".exponent"}, 64'(exponent_out), 64'(v.expo));
      chk({tag, ".sign"}, 64'(aligned_sign), 64'(v.sign));
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input vec_t v, input int hold, input string tag);
    int lat;
    chk({tag, ".ready_before"}, 64'(in_ready), 64'(1'b1));
    a = v.a; b = v.b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat(v.lat)));
    if (out_valid === 1'b1) begin
      check_hold(v, tag);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check_hold(v, {tag, ".stall"});
      end
      out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      chk({tag, ".valid_drop"}, 64'(out_valid), 64'(1'b0));
      chk({tag, ".ready_back"}, 64'(in_ready), 64'(1'b1));
    end
  endtask

  vec_t tbl[12];
  int   seen_valid;

  initial begin
    tbl[0]  = mk(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, 8'h7F, 1'b0, 3'b000, 3'b000, 2);
    tbl[1]  = mk(32'h3F800000, 32'h3F000000, 32'hC0000000, 1'b0, 1'b0, 8'h7F, 1'b0, 3'b000, 3'b000, 3);
    tbl[2]  = mk(32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 8'h7F, 1'b0, 3'b000, 3'b000, 2);
    tbl[3]  = mk(32'h3F800000, 32'h33800000, 32'h80000080, 1'b0, 1'b0, 8'h7F, 1'b0, 3'b000, 3'b000, 26);
    tbl[4]  = mk(32'h3F800000, 32'h2F800000, 32'h80000000, 1'b0, 1'b0, 8'h7F, 1'b1, 3'b000, 3'b000, 34);
    tbl[5]  = mk(32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b100, 3'b000, 1);
    tbl[6]  = mk(32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b001, 3'b000, 1);
    tbl[7]  = mk(32'h3F800000, 32'hFF800000, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b010, 1);
    tbl[8]  = mk(32'h3F800000, 32'hB3800001, 32'h7FFFFF7F, 1'b0, 1'b0, 8'h7F, 1'b1, 3'b000, 3'b000, 26);
    tbl[9]  = mk(32'h3F000000, 32'hBF800000, 32'h40000000, 1'b0, 1'b1, 8'h7F, 1'b0, 3'b000, 3'b000, 3);
    tbl[10] = mk(32'h00000001, 32'h00000002, 32'h00000300, 1'b0, 1'b0, 8'h01, 1'b0, 3'b000, 3'b000, 2);
    tbl[11] = mk(32'h00800000, 32'h00400000, 32'hC0000000, 1'b0, 1'b0, 8'h01, 1'b0, 3'b000, 3'b000, 2);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset.in_ready", 64'(in_ready), 64'(1'b1));
    chk("reset.out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset.result", 64'(aligned_result), 64'(32'd0));
    chk("reset.exponent", 64'(exponent_out), 64'(8'd0));
    chk("reset.a_out", 64'(a_out), 64'(32'd0));
    chk("reset.carry_sticky", 64'({carry_out, sticky}), 64'(2'b00));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i], (i == 1) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Reset asserted while the d=24 operation is still aligning.
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset.out_valid", 64'(out_valid), 64'(1'b0));
    chk("midreset.in_ready", 64'(in_ready), 64'(1'b1));
    chk("midreset.a_out", 64'(a_out), 64'(32'd0));
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    chk("midreset.no_pending_result", 64'(seen_valid), 64'(0));
    run_op(tbl[3], 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 != 3) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 10));
      if (i % 8 == 5) rb[30:0] = ra[30:0];
      run_op(model(ra, rb), $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 SHALL have parameter SAT_SHIFT, default 32: alignment shift saturation limit, in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1): operand handshake.
REQ-005 SHALL have ports a, b, input, 32 each: IEEE-754 single-precision operands.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1): result handshake.
REQ-007 SHALL have port aligned_result, output, 32: hidden bit at [31], guard/round field at [7:0].
REQ-008 SHALL have port carry_out, output, 1: bit 32 of the magnitude sum.
REQ-009 SHALL have ports aligned_sign (output, 1), exponent_out (output, 8), sticky (output, 1).
REQ-010 SHALL have ports a_class and b_class, output, 3 each: {nan, inf, zero} flags per operand.
REQ-011 SHALL have ports sign_a and sign_b, output, 1 each; a_out and b_out, output, 32 each: captured operands passed through.

Function
REQ-012 SHALL define states IDLE, ALIGN, ADD and HOLD; in_ready=1 only in IDLE.
REQ-013 SHALL capture a and b on an in_valid&&in_ready edge and classify them:
- NaN: exponent 0xFF, fraction non-zero.
- inf: exponent 0xFF, fraction zero.
- zero: exponent 0, fraction zero.
- denormal: hidden bit 0, effective exponent 1.
REQ-014 SHALL go from IDLE to HOLD directly when any operand is NaN, inf or zero, with aligned_result=0, carry_out=0 and sticky=0.
REQ-015 SHALL form each mantissa as {hidden, frac[22:0], 8'h00}.
REQ-016 SHALL order operands by larger magnitude (exponent first, then mantissa) and set exponent_out to the larger effective exponent.
REQ-017 SHALL compute d=min(exponent difference, SAT_SHIFT).
REQ-018 SHALL, in ALIGN, shift the smaller mantissa right 1 bit per cycle for d cycles, OR-ing each bit shifted out into sticky; when d=0, ALIGN is skipped.
REQ-019 SHALL, at saturation, set the smaller mantissa to 0 and sticky to the OR of all its original bits.
REQ-020 SHALL, in ADD (1 cycle), use {carry_out, aligned_result} = big + small when signs are equal.
REQ-021 SHALL, in ADD when signs differ, compute big - (small | sticky) with carry_out=0.
REQ-022 SHALL set aligned_sign to the sign of the larger operand; an exactly zero difference gives sign 0.
REQ-023 SHALL assert out_valid in HOLD and hold all outputs stable until out_ready.
REQ-024 SHALL return to IDLE on the out_valid&&out_ready edge; in_ready=1 the next cycle, with no same-cycle accept.
REQ-025 SHALL have latency, from accept edge to out_valid, of d+2 cycles normally and 1 cycle for special operands.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear all outputs and internal registers, with in_ready=1 after reset.
REQ-027 SHALL, on reset mid-ALIGN/ADD/HOLD, abort the operation and drop any pending result.

Configuration
REQ-028 SHALL, with FP_ALIGN_FAST_EN defined, do alignment in one barrel shift in the capture cycle, giving fixed latency 2 (1 for specials) and no ALIGN state.
REQ-029 SHALL, without FP_ALIGN_FAST_EN, use the serial shifter of REQ-018; both builds produce identical output values.

Structure
REQ-030 SHALL place the state enum, the field widths (EXP_W=8, FRAC_W=23, MANT_W=32), EXP_MAX=8'hFF and the class-bit indices in the shared package fp_pkg.
REQ-031 SHALL implement classification as combinational sub-module fp_classify, instantiated once per operand.

Verification
REQ-032 SHALL cover a=3F800000, b=3F800000 -> out_valid 2 cycles after accept, carry_out=1, aligned_result=00000000, exponent_out=7F, sticky=0.
REQ-033 SHALL cover a=3F800000, b=3F000000 -> latency 3 (2 fast), aligned_result=C0000000, carry_out=0, exponent_out=7F.
REQ-034 SHALL cover a=3F800000, b=BF800000 -> aligned_result=0, aligned_sign=0, carry_out=0.
REQ-035 SHALL cover both of these cases:
- b=33800000 (d=24): aligned_result=80000080, sticky=0, latency 26.
- b=2F800000 (d=32): aligned_result=80000000, sticky=1.
REQ-036 SHALL cover a=7FC00000 -> a_class=3'b100, out_valid 1 cycle after accept, a_out=7FC00000.
REQ-037 SHALL cover both of these cases:
- out_ready low 5 cycles: outputs stable throughout.
- rst_n low mid-ALIGN: next cycle out_valid=0, in_ready=1.
